// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receive path.
// Holds the receiver FSM encoding, parity-type codes and the legal prescale ratios.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5,
        ST_DONE   = 3'd6
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    // Anything other than 8 or 16 oversamples at 32.
    function automatic logic [5:0] legal_prescale(input logic [31:0] p);
        if (p == 32'd8) begin
            return PRESCALE_8;
        end
        if (p == 32'd16) begin
            return PRESCALE_16;
        end
        return PRESCALE_32;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with three-point majority vote around the bit centre.
// bit_done_o strobes on the last sample (edge_cnt = P/2+1) together with the voted value.
module uart_rx_sampler (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_s_i,
    input  logic       start_i,
    input  logic       run_i,
    input  logic [5:0] prescale_i,
    output logic       bit_done_o,
    output logic       bit_val_o
);

    logic [5:0] cnt_q, cnt_d;
    logic [1:0] smp_q, smp_d;
    logic [5:0] half;

    assign half = {1'b0, prescale_i[5:1]};

    // The start-detect cycle itself is edge 0 of the start bit, so counting resumes at 1.
    always_comb begin
        cnt_d = '0;
        smp_d = smp_q;
        if (start_i) begin
            cnt_d = 6'd1;
        end else if (run_i) begin
            cnt_d = (cnt_q == prescale_i - 6'd1) ? 6'd0 : cnt_q + 6'd1;
        end
        if (run_i && (cnt_q == half - 6'd1)) begin
            smp_d[0] = rx_s_i;
        end
        if (run_i && (cnt_q == half)) begin
            smp_d[1] = rx_s_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            smp_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            smp_q <= smp_d;
        end
    end

    assign bit_done_o = run_i && (cnt_q == half + 6'd1);
    assign bit_val_o  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_i) | (smp_q[1] & rx_s_i);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: input synchroniser, frame FSM, shift register and parity/stop checks.
// Frame config is latched at start detection; results are published one cycle after DONE.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      parity_error,
    output logic                      framing_error,
    output logic                      busy,
    output logic [2:0]                state_dbg_o
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    rx_state_e              state_q, state_d;
    logic                   par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
    logic [5:0]             presc_q, presc_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d, p_data_q, p_data_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic                   par_err_q, par_err_d, frm_err_q, frm_err_d;
    logic                   dv_q, dv_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                   start_det, bit_done, bit_val;

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign start_det = (state_q == ST_IDLE) && !rx_s;

    uart_rx_sampler u_sampler (
        .clk_i      (CLK),
        .rst_ni     (RST_N),
        .rx_s_i     (rx_s),
        .start_i    (start_det),
        .run_i      (state_q != ST_IDLE),
        .prescale_i (presc_q),
        .bit_done_o (bit_done),
        .bit_val_o  (bit_val)
    );

    always_comb begin
        state_d   = state_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        stop2_d   = stop2_q;
        presc_d   = presc_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        p_data_d  = p_data_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        dv_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d   = ST_START;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    stop2_d   = STOP2;
                    presc_d   = legal_prescale(32'(Prescale));
                    bit_cnt_d = '0;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = bit_val ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d   = {bit_val, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    par_err_d = bit_val != ((^shift_q) ^ (par_typ_q == PAR_ODD));
                    state_d   = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (bit_done) begin
                    frm_err_d = frm_err_q | !bit_val;
                    state_d   = stop2_q ? ST_STOP2 : ST_DONE;
                end
            end
            ST_STOP2: begin
                if (bit_done) begin
                    frm_err_d = frm_err_q | !bit_val;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                perr_d  = par_err_q;
                ferr_d  = frm_err_q;
                state_d = ST_IDLE;
                if (!par_err_q && !frm_err_q) begin
                    p_data_d = shift_q;
                    dv_d     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q    <= '1;
            state_q   <= ST_IDLE;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            stop2_q   <= 1'b0;
            presc_q   <= PRESCALE_32;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            p_data_q  <= '0;
            dv_q      <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], RX_IN};
            state_q   <= state_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            stop2_q   <= stop2_d;
            presc_q   <= presc_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            p_data_q  <= p_data_d;
            dv_q      <= dv_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign P_DATA        = p_data_q;
    assign data_valid    = dv_q;
    assign parity_error  = perr_q;
    assign framing_error = ferr_q;
    assign busy          = (state_q != ST_IDLE);
    assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: table of frames with hand-computed results plus
// glitch, mid-frame reset and 7-bit-width sequences.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx8, rx7;
    logic       par_en, par_typ, stop2;
    logic [5:0] presc;
    logic [7:0] p_data8;
    logic [6:0] p_data7;
    logic       dv8, perr8, ferr8, busy8, dv7, perr7, ferr7, busy7;
    logic [2:0] st8, st7;

    always #5 clk = ~clk;

    uart_rx_cfg #(.DATA_WIDTH(8), .SYNC_STAGES(2), .PRESCALE_WIDTH(6)) dut8 (
        .CLK(clk), .RST_N(rst_n), .RX_IN(rx8), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .STOP2(stop2), .Prescale(presc), .P_DATA(p_data8), .data_valid(dv8),
        .parity_error(perr8), .framing_error(ferr8), .busy(busy8), .state_dbg_o(st8)
    );

    uart_rx_cfg #(.DATA_WIDTH(7), .SYNC_STAGES(2), .PRESCALE_WIDTH(6)) dut7 (
        .CLK(clk), .RST_N(rst_n), .RX_IN(rx7), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .STOP2(stop2), .Prescale(presc), .P_DATA(p_data7), .data_valid(dv7),
        .parity_error(perr7), .framing_error(ferr7), .busy(busy7), .state_dbg_o(st7)
    );

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic       s2;
        logic [5:0] presc;
        int         bp;
        logic       pbit;
        logic [1:0] sbad;
        int         gap;
        logic       noisy;
        logic       ev;
        logic [7:0] ed;
        logic       eperr;
        logic       eferr;
    } vec_t;

    typedef struct {
        int         due;
        int         idx;
        int         cum;
        logic       eperr;
        logic       eferr;
        logic [7:0] ed;
    } pend_t;

    vec_t       vecs[10];
    pend_t      pend_q[$];
    pend_t      pc;
    logic [7:0] exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         dv8_cnt = 0;
    int         dv7_cnt = 0;
    int         exp_dv8 = 0;
    logic       dv8_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every data_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (dv8) begin
            dv8_cnt++;
            check("dv8_busy_low", busy8, 1'b0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dv8_unexpected: got data_valid with P_DATA 0x%0h, expected none", p_data8);
            end else begin
                check("dv8_data", p_data8, exp_q.pop_front());
            end
        end
        if (dv8 && dv8_prev) begin
            tests++;
            fails++;
            $display("FAIL dv8_pulse_width: got 2+ cycles, expected 1");
        end
        dv8_prev <= dv8;
        if (dv7) dv7_cnt++;
    end

    // Deferred per-row result checks, so back-to-back frames are not delayed.
    always @(negedge clk) begin
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            pc = pend_q.pop_front();
            check($sformatf("row%0d_perr", pc.idx), perr8, pc.eperr);
            check($sformatf("row%0d_ferr", pc.idx), ferr8, pc.eferr);
            check($sformatf("row%0d_pdata", pc.idx), p_data8, pc.ed);
            check($sformatf("row%0d_dvcnt", pc.idx), dv8_cnt, pc.cum);
        end
    end

    task automatic drive_bit(input logic sel7, input logic v, input int p, input logic noisy);
        for (int c = 0; c < p; c++) begin
            if (sel7) rx7 = (noisy && c == p / 2) ? ~v : v;
            else      rx8 = (noisy && c == p / 2) ? ~v : v;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic sel7, input logic [7:0] data, input int nbits,
                              input logic pe, input logic pbit, input logic two_stop,
                              input logic [1:0] sbad, input int p, input logic noisy);
        drive_bit(sel7, 1'b0, p, 1'b0);
        par_en  = 1'($urandom_range(0, 1));
        par_typ = 1'($urandom_range(0, 1));
        stop2   = 1'($urandom_range(0, 1));
        presc   = 6'($urandom_range(0, 63));
        for (int i = 0; i < nbits; i++) drive_bit(sel7, data[i], p, noisy);
        if (pe) drive_bit(sel7, pbit, p, 1'b0);
        drive_bit(sel7, ~sbad[0], p, 1'b0);
        if (two_stop) drive_bit(sel7, ~sbad[1], p, 1'b0);
    endtask

    initial begin
        //          data   pe    pt    s2    presc  bp  pbit  sbad   gap noisy ev    ed     eperr eferr
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 6'd32, 32, 1'b0, 2'b00, 2, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 6'd32, 32, 1'b0, 2'b00, 1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{8'h81, 1'b0, 1'b0, 1'b1, 6'd8,  8,  1'b0, 2'b10, 1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[3] = '{8'h7E, 1'b0, 1'b0, 1'b1, 6'd8,  8,  1'b0, 2'b00, 1, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0};
        vecs[4] = '{8'h5A, 1'b1, 1'b0, 1'b0, 6'd8,  8,  1'b0, 2'b00, 0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[5] = '{8'h0F, 1'b1, 1'b1, 1'b0, 6'd16, 16, 1'b1, 2'b00, 1, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 1'b0, 1'b0, 1'b0, 6'd20, 32, 1'b0, 2'b00, 1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 1'b1, 1'b0, 1'b0, 6'd16, 16, 1'b0, 2'b01, 1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[8] = '{8'hC3, 1'b0, 1'b0, 1'b0, 6'd16, 16, 1'b0, 2'b00, 1, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
        vecs[9] = '{8'h96, 1'b1, 1'b0, 1'b0, 6'd16, 16, 1'b1, 2'b01, 1, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b1};

        rst_n = 1'b0; rx8 = 1'b1; rx7 = 1'b1;
        par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; presc = 6'd16;
        repeat (3) @(negedge clk);
        check("rst_pdata", p_data8, 8'h00);
        check("rst_dv", dv8, 1'b0);
        check("rst_perr", perr8, 1'b0);
        check("rst_ferr", ferr8, 1'b0);
        check("rst_busy", busy8, 1'b0);
        check("rst_state", st8, ST_IDLE);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            par_en = vecs[i].pe; par_typ = vecs[i].pt; stop2 = vecs[i].s2; presc = vecs[i].presc;
            if (vecs[i].gap > 0) begin
                rx8 = 1'b1;
                repeat (vecs[i].gap * vecs[i].bp) @(negedge clk);
            end
            if (vecs[i].ev) begin
                exp_q.push_back(vecs[i].ed);
                exp_dv8++;
            end
            send_frame(1'b0, vecs[i].data, 8, vecs[i].pe, vecs[i].pbit, vecs[i].s2,
                       vecs[i].sbad, vecs[i].bp, vecs[i].noisy);
            pend_q.push_back('{cyc + 12, i, exp_dv8, vecs[i].eperr, vecs[i].eferr, vecs[i].ed});
        end
        rx8 = 1'b1;
        repeat (64) @(negedge clk);
        check("pend_drained", pend_q.size(), 0);

        // Short low pulse: start detected, then rejected as a glitch.
        par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; presc = 6'd32;
        rx8 = 1'b0;
        repeat (2) @(negedge clk);
        check("glitch_busy_before_detect", busy8, 1'b0);
        @(negedge clk);
        check("glitch_busy_rise", busy8, 1'b1);
        check("glitch_state_start", st8, ST_START);
        repeat (7) @(negedge clk);
        rx8 = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_busy_end", busy8, 1'b0);
        check("glitch_state_idle", st8, ST_IDLE);
        check("glitch_dvcnt", dv8_cnt, exp_dv8);
        check("glitch_perr_hold", perr8, 1'b1);
        check("glitch_ferr_hold", ferr8, 1'b1);

        // Reset during data bit 4 drops the frame and clears all outputs.
        par_en = 1'b0; stop2 = 1'b0; presc = 6'd16;
        drive_bit(1'b0, 1'b0, 16, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, i[0] ? 1'b1 : 1'b0, 16, 1'b0);
        drive_bit(1'b0, 1'b1, 8, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_pdata", p_data8, 8'h00);
        check("midrst_dv", dv8, 1'b0);
        check("midrst_perr", perr8, 1'b0);
        check("midrst_ferr", ferr8, 1'b0);
        check("midrst_busy", busy8, 1'b0);
        check("midrst_state", st8, ST_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        rx8 = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_dvcnt", dv8_cnt, exp_dv8);
        par_en = 1'b0; stop2 = 1'b0; presc = 6'd16;
        exp_q.push_back(8'hC3);
        exp_dv8++;
        send_frame(1'b0, 8'hC3, 8, 1'b0, 1'b0, 1'b0, 2'b00, 16, 1'b0);
        repeat (12) @(negedge clk);
        check("postrst_pdata", p_data8, 8'hC3);
        check("postrst_perr", perr8, 1'b0);
        check("postrst_ferr", ferr8, 1'b0);
        check("postrst_dvcnt", dv8_cnt, exp_dv8);

        // 7-bit instance, no parity, prescale 16.
        par_en = 1'b0; stop2 = 1'b0; presc = 6'd16;
        send_frame(1'b1, 8'h55, 7, 1'b0, 1'b0, 1'b0, 2'b00, 16, 1'b0);
        repeat (12) @(negedge clk);
        check("w7_pdata", p_data7, 7'h55);
        check("w7_dvcnt", dv7_cnt, 1);
        check("w7_perr", perr7, 1'b0);
        check("w7_ferr", ferr7, 1'b0);
        check("w7_busy", busy7, 1'b0);

        repeat (8) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
